// File: rtl/bcd_mmss_down_timer_if.sv
// Keypad-load / run-control inputs and display / status outputs of the mm:ss countdown timer.
interface bcd_mmss_down_timer_if #(
  parameter int MIN_DIGITS = 2
);
  logic                    load;
  logic [4*MIN_DIGITS-1:0] data_min;
  logic [7:0]              data_sec;
  logic                    start;
  logic                    pause;
  logic [4*MIN_DIGITS-1:0] min_bcd;
  logic [3:0]              sec_tens;
  logic [3:0]              sec_units;
  logic                    zero;
  logic                    running;
  logic                    done;
  logic                    carry_adj;
  logic [1:0]              state;

  modport master (
    output load, data_min, data_sec, start, pause,
    input  min_bcd, sec_tens, sec_units, zero, running, done, carry_adj, state
  );

  modport slave (
    input  load, data_min, data_sec, start, pause,
    output min_bcd, sec_tens, sec_units, zero, running, done, carry_adj, state
  );
endinterface

// File: rtl/bcd_mmss_down_timer.sv
// mm:ss BCD countdown timer: normalising keypad load, start/pause/resume,
// prescaled one-second decrement and a single-cycle done pulse at 00:00.
module bcd_mmss_down_timer #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 1
) (
  input  logic                        clk,
  input  logic                        clear,
  bcd_mmss_down_timer_if.slave        bus
);
  localparam int MW = 4 * MIN_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  state_t          state_q, state_n;
  logic [MW-1:0]   min_q, min_n;
  logic [3:0]      sec_t_q, sec_t_n, sec_u_q, sec_u_n;
  logic            done_q, done_n, carry_q, carry_n;
  logic [PW-1:0]   presc_q, presc_n;

  logic [MW-1:0]   ld_min_sat, ld_min_inc, ld_min;
  logic [3:0]      ld_t_sat, ld_u_sat, ld_t, ld_u;
  logic            ld_clamp, ld_ovf, ld_carry;
  logic [MW-1:0]   dec_min;
  logic [3:0]      dec_t, dec_u;
  logic            dec_zero, is_zero, tick;

  // Saturate a keypad nibble into the decimal range.
  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // BCD increment of the minute field; MSB of the result is the overflow out of the top digit.
  function automatic logic [MW:0] bcd_inc(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          c;
    r = m;
    c = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // BCD decrement of the minute field; only used when a borrow out of the seconds exists.
  function automatic logic [MW-1:0] bcd_dec(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          b;
    r = m;
    b = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Load path: clamp digits, fold seconds tens >=6 into minutes, saturate at the maximum time.
  always_comb begin
    ld_clamp   = 1'b0;
    ld_min_sat = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      ld_min_sat[4*i +: 4] = sat_digit(bus.data_min[4*i +: 4]);
      if (bus.data_min[4*i +: 4] > 4'd9) ld_clamp = 1'b1;
    end
    ld_t_sat = sat_digit(bus.data_sec[7:4]);
    ld_u_sat = sat_digit(bus.data_sec[3:0]);
    if ((bus.data_sec[7:4] > 4'd9) || (bus.data_sec[3:0] > 4'd9)) ld_clamp = 1'b1;
    {ld_ovf, ld_min_inc} = bcd_inc(ld_min_sat);
    ld_min   = ld_min_sat;
    ld_t     = ld_t_sat;
    ld_u     = ld_u_sat;
    ld_carry = ld_clamp;
    if (ld_t_sat >= 4'd6) begin
      ld_carry = 1'b1;
      if (ld_ovf) begin
        ld_t = 4'd5;
        ld_u = 4'd9;
      end else begin
        ld_min = ld_min_inc;
        ld_t   = ld_t_sat - 4'd6;
      end
    end
  end

  // One-second decrement with units -> tens -> minutes borrow.
  always_comb begin
    dec_min = min_q;
    dec_t   = sec_t_q;
    dec_u   = sec_u_q;
    if (sec_u_q != 4'd0) begin
      dec_u = sec_u_q - 4'd1;
    end else begin
      dec_u = 4'd9;
      if (sec_t_q != 4'd0) begin
        dec_t = sec_t_q - 4'd1;
      end else begin
        dec_t   = 4'd5;
        dec_min = bcd_dec(min_q);
      end
    end
    dec_zero = (dec_min == '0) && (dec_t == 4'd0) && (dec_u == 4'd0);
  end

  assign is_zero = (min_q == '0) && (sec_t_q == 4'd0) && (sec_u_q == 4'd0);
  assign tick    = (presc_q == PRE_LAST);

  // Control FSM next state: load > pause > start > tick.
  always_comb begin
    state_n = state_q;
    min_n   = min_q;
    sec_t_n = sec_t_q;
    sec_u_n = sec_u_q;
    carry_n = carry_q;
    presc_n = presc_q;
    done_n  = 1'b0;
    if (bus.load) begin
      state_n = IDLE;
      min_n   = ld_min;
      sec_t_n = ld_t;
      sec_u_n = ld_u;
      carry_n = ld_carry;
      presc_n = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.pause && bus.start && !is_zero) begin
            state_n = RUN;
            presc_n = '0;
          end
        end
        RUN: begin
          if (bus.pause) begin
            state_n = PAUSE;
          end else if (tick) begin
            presc_n = '0;
            min_n   = dec_min;
            sec_t_n = dec_t;
            sec_u_n = dec_u;
            if (dec_zero) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end else begin
            presc_n = presc_q + 1'b1;
          end
        end
        PAUSE: begin
          if (!bus.pause && bus.start) state_n = RUN;
        end
        default: ;
      endcase
    end
  end

  // State and digit registers; clear returns everything to an idle 00:00.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      min_q   <= '0;
      sec_t_q <= 4'd0;
      sec_u_q <= 4'd0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_n;
      min_q   <= min_n;
      sec_t_q <= sec_t_n;
      sec_u_q <= sec_u_n;
      done_q  <= done_n;
      carry_q <= carry_n;
      presc_q <= presc_n;
    end
  end

  assign bus.min_bcd   = min_q;
  assign bus.sec_tens  = sec_t_q;
  assign bus.sec_units = sec_u_q;
  assign bus.zero      = is_zero;
  assign bus.running   = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.carry_adj = carry_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_bcd_mmss_down_timer.sv
// Bench for the mm:ss countdown timer: two instances (TICK_DIV 1 and 4) share stimulus;
// a seconds-count reference model feeds per-instance expectation queues drained by a monitor.
module tb_bcd_mmss_down_timer;
  localparam int MD   = 2;
  localparam int MW   = 4 * MD;
  localparam int MAXM = 10 ** MD - 1;
  localparam int OW   = MW + 14;

  typedef logic [OW-1:0] obs_t;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  bcd_mmss_down_timer_if #(.MIN_DIGITS(MD)) if1 ();
  bcd_mmss_down_timer_if #(.MIN_DIGITS(MD)) if4 ();

  bcd_mmss_down_timer #(.MIN_DIGITS(MD), .TICK_DIV(1)) u1 (.clk(clk), .clear(clear), .bus(if1.slave));
  bcd_mmss_down_timer #(.MIN_DIGITS(MD), .TICK_DIV(4)) u4 (.clk(clk), .clear(clear), .bus(if4.slave));

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: time held as total seconds
  int m_total [2];
  int m_st    [2];
  int m_pc    [2];
  bit m_done  [2];
  bit m_carry [2];
  int td      [2] = '{1, 4};

  obs_t q1 [$];
  obs_t q4 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_step(input int k, input bit c, input bit l, input logic [MW-1:0] dm,
                            input logic [7:0] ds, input bit s, input bit p);
    int m, t, u, sec, d;
    bit clamp;
    if (c) begin
      m_total[k] = 0; m_st[k] = 0; m_pc[k] = 0; m_done[k] = 0; m_carry[k] = 0;
    end else if (l) begin
      m = 0;
      clamp = 0;
      for (int i = 0; i < MD; i++) begin
        d = int'(dm[4*i +: 4]);
        if (d > 9) begin d = 9; clamp = 1; end
        m += d * (10 ** i);
      end
      t = int'(ds[7:4]);
      u = int'(ds[3:0]);
      if (t > 9) begin t = 9; clamp = 1; end
      if (u > 9) begin u = 9; clamp = 1; end
      sec = t * 10 + u;
      m_total[k] = m * 60 + sec;
      if (m_total[k] > MAXM * 60 + 59) m_total[k] = MAXM * 60 + 59;
      m_carry[k] = clamp || (sec >= 60);
      m_st[k] = 0; m_pc[k] = 0; m_done[k] = 0;
    end else begin
      m_done[k] = 0;
      case (m_st[k])
        0: if (!p && s && m_total[k] != 0) begin m_st[k] = 1; m_pc[k] = 0; end
        1: begin
          if (p) m_st[k] = 2;
          else if (m_pc[k] == td[k] - 1) begin
            m_pc[k] = 0;
            m_total[k]--;
            if (m_total[k] == 0) begin m_st[k] = 3; m_done[k] = 1; end
          end else m_pc[k]++;
        end
        2: if (!p && s) m_st[k] = 1;
        default: ;
      endcase
    end
  endtask

  function automatic obs_t expect_obs(input int k);
    int mm, ss;
    logic [MW-1:0] mb;
    mm = m_total[k] / 60;
    ss = m_total[k] % 60;
    mb = '0;
    for (int i = 0; i < MD; i++) begin
      mb[4*i +: 4] = 4'(mm % 10);
      mm = mm / 10;
    end
    return {mb, 4'(ss / 10), 4'(ss % 10), (m_total[k] == 0), (m_st[k] == 1),
            m_done[k], m_carry[k], 2'(m_st[k])};
  endfunction

  task automatic step(input bit c, input bit l, input logic [MW-1:0] dm, input logic [7:0] ds,
                      input bit s, input bit p);
    @(negedge clk);
    clear = c;
    if1.load = l; if1.data_min = dm; if1.data_sec = ds; if1.start = s; if1.pause = p;
    if4.load = l; if4.data_min = dm; if4.data_sec = ds; if4.start = s; if4.pause = p;
    model_step(0, c, l, dm, ds, s, p);
    model_step(1, c, l, dm, ds, s, p);
    q1.push_back(expect_obs(0));
    q4.push_back(expect_obs(1));
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, '0, 8'h00, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // scoreboard monitor: every cycle each instance presents a new display/status word
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("sb_u1", {if1.min_bcd, if1.sec_tens, if1.sec_units, if1.zero, if1.running,
                        if1.done, if1.carry_adj, if1.state}, e);
      end
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check("sb_u4", {if4.min_bcd, if4.sec_tens, if4.sec_units, if4.zero, if4.running,
                        if4.done, if4.carry_adj, if4.state}, e);
      end
    end
  end

  initial begin
    bit c, l, s, p;
    logic [MW-1:0] dm;
    logic [7:0] ds;
    clear = 1'b1;
    if1.load = 0; if1.data_min = '0; if1.data_sec = '0; if1.start = 0; if1.pause = 0;
    if4.load = 0; if4.data_min = '0; if4.data_sec = '0; if4.start = 0; if4.pause = 0;

    step(1, 0, '0, 8'h00, 0, 0);
    settle();
    check("rst_state", if4.state, 2'd0);
    check("rst_digits", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h0000);
    check("rst_carry", if4.carry_adj, 1'b0);
    check("rst_done", if4.done, 1'b0);

    step(0, 1, 8'h00, 8'h75, 0, 0); settle();
    check("ld_0075", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h0115);
    check("ld_0075_carry", if4.carry_adj, 1'b1);
    step(0, 1, 8'h12, 8'h34, 0, 0); settle();
    check("ld_1234", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h1234);
    check("ld_1234_carry", if4.carry_adj, 1'b0);
    step(0, 1, 8'h99, 8'h95, 0, 0); settle();
    check("ld_9995", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h9959);
    check("ld_9995_carry", if4.carry_adj, 1'b1);
    step(0, 1, 8'h9F, 8'hAA, 0, 0); settle();
    check("ld_9FAA", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h9959);
    check("ld_9FAA_carry", if4.carry_adj, 1'b1);

    step(0, 1, 8'h01, 8'h00, 0, 0);
    step(0, 0, '0, 8'h00, 1, 0); settle();
    check("div4_running", if4.running, 1'b1);
    idle(3); settle();
    check("div4_pre_tick", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h0100);
    idle(1); settle();
    check("div4_tick1", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h0059);
    idle(3); settle();
    check("div4_hold", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h0059);
    idle(1); settle();
    check("div4_tick2", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h0058);

    idle(2);
    step(0, 0, '0, 8'h00, 0, 1); settle();
    check("pause_state", if4.state, 2'd2);
    idle(10); settle();
    check("pause_frozen", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h0058);
    step(0, 0, '0, 8'h00, 1, 0); settle();
    check("resume_state", if4.state, 2'd1);
    idle(1); settle();
    check("resume_hold", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h0058);
    idle(1); settle();
    check("resume_tick", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h0057);

    step(0, 1, 8'h00, 8'h02, 0, 0);
    step(0, 0, '0, 8'h00, 1, 0);
    idle(1); settle();
    check("cd_0001", {if1.min_bcd, if1.sec_tens, if1.sec_units}, 16'h0001);
    idle(1); settle();
    check("cd_0000", {if1.min_bcd, if1.sec_tens, if1.sec_units}, 16'h0000);
    check("cd_done", if1.done, 1'b1);
    check("cd_state", if1.state, 2'd3);
    check("cd_zero", if1.zero, 1'b1);
    check("cd_running", if1.running, 1'b0);
    idle(1); settle();
    check("cd_done_clr", if1.done, 1'b0);
    check("cd_state_hold", if1.state, 2'd3);

    step(0, 1, 8'h05, 8'h75, 0, 0);
    step(0, 0, '0, 8'h00, 1, 0);
    idle(2);
    step(1, 1, 8'h12, 8'h34, 1, 0); settle();
    check("clr_digits", {if4.min_bcd, if4.sec_tens, if4.sec_units}, 16'h0000);
    check("clr_state", if4.state, 2'd0);
    check("clr_carry", if4.carry_adj, 1'b0);
    step(0, 0, '0, 8'h00, 1, 0); settle();
    check("start_zero_u4", if4.state, 2'd0);
    check("start_zero_u1", if1.state, 2'd0);

    for (int n = 0; n < 800; n++) begin
      c = ($urandom_range(0, 99) < 2);
      l = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin
        dm = '0;
        ds = 8'($urandom_range(0, 8));
      end else begin
        dm = MW'($urandom);
        ds = 8'($urandom);
      end
      step(c, l, dm, ds, s, p);
    end

    repeat (2) @(posedge clk);
    #3;
    check("sb_drain", q1.size() + q4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
